bsg_ring_stop_arb: RTL and testbench

Per-tile ring stop controller for a mesh stitched into a unidirectional ring. Each instance owns one slot of the forward ring and one of the backward ring, and arbitrates that slot between upstream pass-through traffic and local injection. It ejects packets addressed to its tile. Starving injectors throttle upstream nodes by sending tokens on the backward ring. One instance sits at every mesh position. The stitch's forward and backward links and its per-tile id connect directly to these ports.

---
 rtl/bsg_ring_stop_pkg.sv | 19 +
 rtl/bsg_ring_stop_starve.sv | 72 +++++++
 rtl/bsg_ring_stop_arb.sv | 117 +++++++++++
 tb/tb_bsg_ring_stop_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_ring_stop_pkg.sv
// Shared types for the ring stop: starvation FSM states and payload struct macros.
`ifndef BSG_RING_STOP_PKG_SV
`define BSG_RING_STOP_PKG_SV

// Forward-ring slot payload and backward-ring throttle token, sized by the instantiating module.
`define BSG_RING_PKT_S(w, iw) struct packed { logic v; logic [(iw)-1:0] dest; logic [(w)-1:0] data; }
`define BSG_RING_THR_S(iw) struct packed { logic v; logic [(iw)-1:0] id; }

package bsg_ring_stop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STARVE = 2'd2
  } starve_state_e;

endpackage

`endif

// File: rtl/bsg_ring_stop_starve.sv
// Starvation tracker: counts consecutive blocked inject cycles and flags STARVE at the limit.
module bsg_ring_stop_starve
  import bsg_ring_stop_pkg::*;
#(
  parameter int unsigned starve_limit_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inj_v_i,
  input  logic inj_ready_i,
  output logic starve_o
);

  localparam int unsigned cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(starve_limit_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(starve_limit_p);

  starve_state_e           state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    blocked;

  assign blocked = inj_v_i & ~inj_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter reflects blocked cycles seen so far, saturating at the limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (blocked) begin
          cnt_d   = cnt_width_lp'(1);
          state_d = (cnt_q == cnt_last_lp) ? STARVE : WAIT;
        end
      end
      WAIT: begin
        if (!blocked) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != cnt_max_lp) cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_q == cnt_last_lp) state_d = STARVE;
        end
      end
      STARVE: begin
        if (!blocked) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != cnt_max_lp) begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign starve_o = (state_q == STARVE);

endmodule

// File: rtl/bsg_ring_stop_arb.sv
// Ring stop: arbitrates the forward slot between pass-through and local inject,
// ejects packets for this tile, and relays/issues throttle tokens on the backward ring.
module bsg_ring_stop_arb
  import bsg_ring_stop_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned id_width_p     = 6,
  parameter int unsigned starve_limit_p = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [id_width_p-1:0] my_id_i,
  input  logic                  ring_v_i,
  input  logic [id_width_p-1:0] ring_dest_i,
  input  logic [width_p-1:0]    ring_data_i,
  output logic                  ring_v_o,
  output logic [id_width_p-1:0] ring_dest_o,
  output logic [width_p-1:0]    ring_data_o,
  input  logic                  thr_v_i,
  input  logic [id_width_p-1:0] thr_id_i,
  output logic                  thr_v_o,
  output logic [id_width_p-1:0] thr_id_o,
  input  logic                  inj_v_i,
  input  logic [id_width_p-1:0] inj_dest_i,
  input  logic [width_p-1:0]    inj_data_i,
  output logic                  inj_ready_o,
  output logic                  ej_v_o,
  output logic [width_p-1:0]    ej_data_o,
  input  logic                  ej_yumi_i,
  output logic                  starve_o
);

  typedef `BSG_RING_PKT_S(width_p, id_width_p) pkt_s;
  typedef `BSG_RING_THR_S(id_width_p) thr_s;

  pkt_s               ring_q, ring_d;
  thr_s               thr_q, thr_d;
  logic               ej_v_q, ej_v_d;
  logic [width_p-1:0] ej_data_q, ej_data_d;

  logic hit, eject, slot_free, thr_own, thr_foreign, allowed, starve;

  assign hit         = ring_v_i && (ring_dest_i == my_id_i);
  assign eject       = hit && (!ej_v_q || ej_yumi_i);
  assign slot_free   = !ring_v_i || eject;
  assign thr_own     = thr_v_i && (thr_id_i == my_id_i);
  assign thr_foreign = thr_v_i && !thr_own;
  assign allowed     = slot_free && !thr_foreign;
  assign inj_ready_o = inj_v_i && allowed;

  bsg_ring_stop_starve #(
    .starve_limit_p(starve_limit_p)
  ) u_starve (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inj_v_i    (inj_v_i),
    .inj_ready_i(inj_ready_o),
    .starve_o   (starve)
  );

  // Forward slot: inject wins a free slot, else pass through (emptied if ejected).
  always_comb begin
    ring_d.v    = ring_v_i && !eject;
    ring_d.dest = ring_dest_i;
    ring_d.data = ring_data_i;
    if (inj_ready_o) begin
      ring_d.v    = 1'b1;
      ring_d.dest = inj_dest_i;
      ring_d.data = inj_data_i;
    end
  end

  // Backward slot: foreign tokens have priority; our own returning token frees the slot.
  always_comb begin
    thr_d = '0;
    if (thr_foreign) begin
      thr_d.v  = 1'b1;
      thr_d.id = thr_id_i;
    end else if (starve) begin
      thr_d.v  = 1'b1;
      thr_d.id = my_id_i;
    end
  end

  always_comb begin
    ej_v_d    = ej_v_q && !ej_yumi_i;
    ej_data_d = ej_data_q;
    if (eject) begin
      ej_v_d    = 1'b1;
      ej_data_d = ring_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ring_q    <= '0;
      thr_q     <= '0;
      ej_v_q    <= 1'b0;
      ej_data_q <= '0;
    end else begin
      ring_q    <= ring_d;
      thr_q     <= thr_d;
      ej_v_q    <= ej_v_d;
      ej_data_q <= ej_data_d;
    end
  end

  assign ring_v_o    = ring_q.v;
  assign ring_dest_o = ring_q.dest;
  assign ring_data_o = ring_q.data;
  assign thr_v_o     = thr_q.v;
  assign thr_id_o    = thr_q.id;
  assign ej_v_o      = ej_v_q;
  assign ej_data_o   = ej_data_q;
  assign starve_o    = starve;

endmodule

// File: tb/tb_bsg_ring_stop_arb.sv
// Bench: directed checks on one stop, then an 8-stop ring under random traffic
// scored by a packet-level delivery model.
module tb_bsg_ring_stop_arb;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 6;
  localparam int unsigned SL = 4;
  localparam int unsigned N  = 8;
  localparam int unsigned BLOCK_BOUND = SL + 2 * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- single stop, my_id = 5 ----------------
  logic          d_ring_v, d_thr_v, d_inj_v, d_yumi;
  logic [IW-1:0] d_ring_dest, d_thr_id, d_inj_dest;
  logic [W-1:0]  d_ring_data, d_inj_data;
  logic          o_ring_v, o_thr_v, o_ready, o_ej_v, o_starve;
  logic [IW-1:0] o_ring_dest, o_thr_id;
  logic [W-1:0]  o_ring_data, o_ej_data;

  bsg_ring_stop_arb #(.width_p(W), .id_width_p(IW), .starve_limit_p(SL)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .my_id_i(6'd5),
    .ring_v_i(d_ring_v), .ring_dest_i(d_ring_dest), .ring_data_i(d_ring_data),
    .ring_v_o(o_ring_v), .ring_dest_o(o_ring_dest), .ring_data_o(o_ring_data),
    .thr_v_i(d_thr_v), .thr_id_i(d_thr_id), .thr_v_o(o_thr_v), .thr_id_o(o_thr_id),
    .inj_v_i(d_inj_v), .inj_dest_i(d_inj_dest), .inj_data_i(d_inj_data),
    .inj_ready_o(o_ready), .ej_v_o(o_ej_v), .ej_data_o(o_ej_data),
    .ej_yumi_i(d_yumi), .starve_o(o_starve)
  );

  // ---------------- 8-stop ring ----------------
  logic          r_v     [N];
  logic [IW-1:0] r_dest  [N];
  logic [W-1:0]  r_data  [N];
  logic          t_v     [N];
  logic [IW-1:0] t_id    [N];
  logic          n_inj_v [N];
  logic [IW-1:0] n_inj_dest [N];
  logic [W-1:0]  n_inj_data [N];
  logic          n_ready [N];
  logic          n_ej_v  [N];
  logic [W-1:0]  n_ej_data [N];
  logic          n_yumi  [N];
  logic          n_starve [N];

  for (genvar g = 0; g < N; g++) begin : g_node
    bsg_ring_stop_arb #(.width_p(W), .id_width_p(IW), .starve_limit_p(SL)) u_stop (
      .clk_i(clk), .reset_n_i(rst_n), .my_id_i(6'(g)),
      .ring_v_i(r_v[(g+N-1)%N]), .ring_dest_i(r_dest[(g+N-1)%N]), .ring_data_i(r_data[(g+N-1)%N]),
      .ring_v_o(r_v[g]), .ring_dest_o(r_dest[g]), .ring_data_o(r_data[g]),
      .thr_v_i(t_v[(g+1)%N]), .thr_id_i(t_id[(g+1)%N]),
      .thr_v_o(t_v[g]), .thr_id_o(t_id[g]),
      .inj_v_i(n_inj_v[g]), .inj_dest_i(n_inj_dest[g]), .inj_data_i(n_inj_data[g]),
      .inj_ready_o(n_ready[g]), .ej_v_o(n_ej_v[g]), .ej_data_o(n_ej_data[g]),
      .ej_yumi_i(n_yumi[g]), .starve_o(n_starve[g])
    );
  end

  // Delivery model: every outstanding packet tag maps to the node that must eject it.
  int          exp_dest [int unsigned];
  int unsigned tag = 1;
  bit          acc [N];
  int          blk [N];
  int          max_blk = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_cycle(input bit en);
    bit ok;
    @(negedge clk);
    for (int n = 0; n < N; n++) begin
      if (acc[n]) n_inj_v[n] = 1'b0;
      if (en && !n_inj_v[n] && $urandom_range(0, 23) == 0) begin
        n_inj_v[n]    = 1'b1;
        n_inj_dest[n] = IW'($urandom_range(0, N - 1));
        n_inj_data[n] = tag;
        tag++;
      end
      n_yumi[n] = n_ej_v[n] && ($urandom_range(0, 3) != 0);
    end
    #1;
    for (int n = 0; n < N; n++) begin
      acc[n] = n_inj_v[n] && n_ready[n];
      if (acc[n]) exp_dest[n_inj_data[n]] = n;
      if (acc[n]) exp_dest[n_inj_data[n]] = int'(n_inj_dest[n]);
      if (n_inj_v[n] && !n_ready[n]) begin
        blk[n]++;
        if (blk[n] > max_blk) max_blk = blk[n];
      end else begin
        blk[n] = 0;
      end
      if (n_yumi[n]) begin
        ok = 1'b0;
        if (exp_dest.exists(n_ej_data[n])) begin
          ok = (exp_dest[n_ej_data[n]] == n);
          exp_dest.delete(n_ej_data[n]);
        end
        if (!ok) $display("eject detail: node=%0d tag=%0d", n, n_ej_data[n]);
        chk("eject_at_dest_once", 64'(ok), 64'd1);
      end
    end
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int n = 0; n < N; n++) if (n_inj_v[n] && !acc[n]) p = 1'b1;
    return p;
  endfunction

  initial begin
    rst_n = 1'b0;
    d_ring_v = 0; d_ring_dest = '0; d_ring_data = '0;
    d_thr_v = 0; d_thr_id = '0; d_inj_v = 0; d_inj_dest = '0; d_inj_data = '0; d_yumi = 0;
    for (int n = 0; n < N; n++) begin
      n_inj_v[n] = 0; n_inj_dest[n] = '0; n_inj_data[n] = '0; n_yumi[n] = 0;
      acc[n] = 0; blk[n] = 0;
    end

    // reset holds every registered output at zero despite random inputs
    for (int i = 0; i < 3; i++) begin
      d_ring_v = 1'($urandom); d_ring_dest = IW'($urandom); d_ring_data = $urandom;
      d_thr_v = 1'($urandom); d_thr_id = IW'($urandom);
      d_inj_v = 1'($urandom); d_inj_dest = IW'($urandom); d_inj_data = $urandom;
      d_yumi = 1'($urandom);
      step();
      chk("reset_outputs_zero",
          64'(|{o_ring_v, o_ring_dest, o_ring_data, o_thr_v, o_thr_id, o_ej_v, o_ej_data, o_starve}),
          64'd0);
    end
    d_ring_v = 0; d_ring_dest = '0; d_ring_data = '0;
    d_thr_v = 0; d_thr_id = '0; d_inj_v = 0; d_inj_dest = '0; d_inj_data = '0; d_yumi = 0;
    rst_n = 1'b1;
    step();
    chk("post_reset_ring_v", 64'(o_ring_v), 64'd0);
    chk("post_reset_thr_v", 64'(o_thr_v), 64'd0);
    step();

    // hit ejects into empty buffer
    d_ring_v = 1; d_ring_dest = 6'd5; d_ring_data = 32'hA5;
    step();
    chk("eject_v", 64'(o_ej_v), 64'd1);
    chk("eject_data", 64'(o_ej_data), 64'hA5);
    chk("eject_slot_empty", 64'(o_ring_v), 64'd0);

    // buffer full: hit passes through, inject blocked
    d_ring_data = 32'h11; d_inj_v = 1; d_inj_dest = 6'd2; d_inj_data = 32'h22;
    #1;
    chk("full_inj_blocked", 64'(o_ready), 64'd0);
    step();
    chk("full_pass_v", 64'(o_ring_v), 64'd1);
    chk("full_pass_dest", 64'(o_ring_dest), 64'd5);
    chk("full_pass_data", 64'(o_ring_data), 64'h11);
    chk("full_keep_data", 64'(o_ej_data), 64'hA5);

    // yumi with hit reloads buffer and frees slot for inject
    d_ring_data = 32'h33; d_yumi = 1;
    #1;
    chk("yumi_hit_inj_ready", 64'(o_ready), 64'd1);
    step();
    chk("reload_v", 64'(o_ej_v), 64'd1);
    chk("reload_data", 64'(o_ej_data), 64'h33);
    chk("inject_v", 64'(o_ring_v), 64'd1);
    chk("inject_dest", 64'(o_ring_dest), 64'd2);
    chk("inject_data", 64'(o_ring_data), 64'h22);

    d_ring_v = 0; d_inj_v = 0; d_yumi = 1;
    step();
    chk("yumi_clears_v", 64'(o_ej_v), 64'd0);
    chk("idle_ring_v", 64'(o_ring_v), 64'd0);
    d_yumi = 0;

    // continuous foreign traffic starves the injector
    d_ring_v = 1; d_ring_dest = 6'd3; d_ring_data = 32'h77;
    d_inj_v = 1; d_inj_dest = 6'd2; d_inj_data = 32'h44;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("starve_not_yet", 64'(o_starve), 64'd0);
    end
    step();
    chk("starve_asserted", 64'(o_starve), 64'd1);
    chk("token_not_yet", 64'(o_thr_v), 64'd0);
    step();
    chk("token_v", 64'(o_thr_v), 64'd1);
    chk("token_id", 64'(o_thr_id), 64'd5);
    chk("starve_held", 64'(o_starve), 64'd1);
    chk("starve_pass_dest", 64'(o_ring_dest), 64'd3);
    d_ring_v = 0;
    #1;
    chk("starve_free_ready", 64'(o_ready), 64'd1);
    step();
    chk("starve_cleared", 64'(o_starve), 64'd0);
    chk("starve_inj_v", 64'(o_ring_v), 64'd1);
    chk("starve_inj_data", 64'(o_ring_data), 64'h44);
    d_inj_v = 0;
    step();
    chk("token_stops", 64'(o_thr_v), 64'd0);

    // foreign token forwarded and blocks inject; own token dropped
    d_thr_v = 1; d_thr_id = 6'd3; d_inj_v = 1; d_inj_data = 32'h55;
    #1;
    chk("foreign_tok_blocks", 64'(o_ready), 64'd0);
    step();
    chk("fwd_token_v", 64'(o_thr_v), 64'd1);
    chk("fwd_token_id", 64'(o_thr_id), 64'd3);
    d_thr_id = 6'd5;
    #1;
    chk("own_tok_allows", 64'(o_ready), 64'd1);
    step();
    chk("own_tok_dropped", 64'(o_thr_v), 64'd0);
    chk("own_tok_inject", 64'(o_ring_v), 64'd1);
    d_thr_v = 0; d_inj_v = 0;
    step();

    // 8-stop ring under random traffic, then drain
    for (int c = 0; c < 10000; c++) ring_cycle(1'b1);
    for (int c = 0; c < 3000; c++) begin
      ring_cycle(1'b0);
      if (exp_dest.size() == 0 && !any_pending()) break;
    end
    chk("ring_drained", 64'(exp_dest.size()), 64'd0);
    chk("ring_no_pending_inject", 64'(any_pending()), 64'd0);
    chk("ring_traffic_seen", 64'(tag > 200), 64'd1);
    chk("ring_block_bound", 64'(max_blk <= int'(BLOCK_BOUND)), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
